alu_seq_nb: RTL and testbench

- Parametrised N-bit sequential ALU, successor to the combinational n-bit ALU.
- Keeps the eight single-cycle operations and registers every output.
- Adds status flags, a Start/Busy/Done handshake, and multi-cycle unsigned multiply and divide (shift-add / restoring, one bit per clock).
- Sits between the operand register file and the result writeback / display logic of the lab datapath.

---
 rtl/alu_seq_nb.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq_nb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_nb.sv
// Sequential N-bit ALU: registered single-cycle ops plus shift-add multiply and
// restoring divide (one bit per clock), with Start/Busy/Done handshake and status flags.
module alu_seq_nb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CB_in,
  input  logic [3:0]   Mode,
  output logic [N-1:0] Result,
  output logic [N-1:0] Result_hi,
  output logic         CB_out,
  output logic         Zero,
  output logic         Neg,
  output logic         Ovf,
  output logic         DivZero,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = $clog2(N + 1);

  localparam logic [3:0] M_ADD = 4'd0;
  localparam logic [3:0] M_SUB = 4'd1;
  localparam logic [3:0] M_AND = 4'd2;
  localparam logic [3:0] M_OR  = 4'd3;
  localparam logic [3:0] M_XOR = 4'd4;
  localparam logic [3:0] M_NOT = 4'd5;
  localparam logic [3:0] M_INC = 4'd6;
  localparam logic [3:0] M_DEC = 4'd7;
  localparam logic [3:0] M_MUL = 4'd8;
  localparam logic [3:0] M_DIV = 4'd9;

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   a_q, b_q;
  logic           cb_q;
  logic [3:0]     mode_q;
  logic [N-1:0]   work_hi, work_lo;
  logic           single_pend;

  logic           accept, start_multi, last_iter, finish_multi, write_out;

  logic [N:0]     mul_sum, div_shift, div_trial;
  logic           div_ok;
  logic [N-1:0]   nxt_hi, nxt_lo;

  logic [N:0]     add_sum, sub_diff, inc_sum, dec_diff;
  logic [N-1:0]   s_res;
  logic           s_cb, s_ovf;

  logic [N-1:0]   fin_res, fin_hi;
  logic           fin_cb, fin_zero, fin_ovf, fin_dz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_multi) state_d = CALC;
      CALC: if (last_iter)   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy         = (state_q == CALC);
    accept       = (state_q == IDLE) && Start;
    start_multi  = accept && ((Mode == M_MUL) || (Mode == M_DIV));
    last_iter    = (cnt_q == CW'(N - 1));
    finish_multi = (state_q == CALC) && last_iter;
    write_out    = single_pend || finish_multi;
  end

  // One iteration: MUL shifts the partial product right, DIV shifts the remainder left.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : {(N+1){1'b0}});
    div_shift = {work_hi, work_lo[N-1]};
    div_trial = div_shift - {1'b0, b_q};
    div_ok    = ~div_trial[N];
    if (mode_q == M_MUL) begin
      nxt_hi = mul_sum[N:1];
      nxt_lo = {mul_sum[0], work_lo[N-1:1]};
    end else begin
      nxt_hi = div_ok ? div_trial[N-1:0] : div_shift[N-1:0];
      nxt_lo = {work_lo[N-2:0], div_ok};
    end
  end

  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cb_q};
    sub_diff = {1'b0, a_q} - {1'b0, b_q} - {{N{1'b0}}, cb_q};
    inc_sum  = {1'b0, a_q} + (N+1)'(1);
    dec_diff = {1'b0, a_q} - (N+1)'(1);
    s_res = '0;
    s_cb  = 1'b0;
    s_ovf = 1'b0;
    case (mode_q)
      M_ADD: begin
        s_res = add_sum[N-1:0];
        s_cb  = add_sum[N];
        s_ovf = (a_q[N-1] == b_q[N-1]) && (add_sum[N-1] != a_q[N-1]);
      end
      M_SUB: begin
        s_res = sub_diff[N-1:0];
        s_cb  = sub_diff[N];
        s_ovf = (a_q[N-1] != b_q[N-1]) && (sub_diff[N-1] != a_q[N-1]);
      end
      M_AND: s_res = a_q & b_q;
      M_OR:  s_res = a_q | b_q;
      M_XOR: s_res = a_q ^ b_q;
      M_NOT: s_res = ~a_q;
      M_INC: begin
        s_res = inc_sum[N-1:0];
        s_cb  = inc_sum[N];
      end
      M_DEC: begin
        s_res = dec_diff[N-1:0];
        s_cb  = dec_diff[N];
      end
      default: ;
    endcase
  end

  always_comb begin
    fin_res  = s_res;
    fin_hi   = '0;
    fin_cb   = s_cb;
    fin_ovf  = s_ovf;
    fin_zero = (s_res == '0);
    fin_dz   = 1'b0;
    if (finish_multi) begin
      fin_res = nxt_lo;
      fin_hi  = nxt_hi;
      fin_cb  = 1'b0;
      if (mode_q == M_MUL) begin
        fin_zero = (nxt_hi == '0) && (nxt_lo == '0);
        fin_ovf  = (nxt_hi != '0);
      end else begin
        fin_zero = (nxt_lo == '0);
        fin_ovf  = 1'b0;
        fin_dz   = (b_q == '0);
      end
    end
  end

  // Operands are captured only on an accepted Start; outputs change only with Done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cb_q        <= 1'b0;
      mode_q      <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      single_pend <= 1'b0;
      Result      <= '0;
      Result_hi   <= '0;
      CB_out      <= 1'b0;
      Zero        <= 1'b0;
      Neg         <= 1'b0;
      Ovf         <= 1'b0;
      DivZero     <= 1'b0;
      Done        <= 1'b0;
    end else begin
      single_pend <= accept && !start_multi;
      Done        <= write_out;
      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        cb_q    <= CB_in;
        mode_q  <= Mode;
        cnt_q   <= '0;
        work_hi <= '0;
        work_lo <= (Mode == M_MUL) ? B : A;
      end else if (state_q == CALC) begin
        work_hi <= nxt_hi;
        work_lo <= nxt_lo;
        cnt_q   <= cnt_q + CW'(1);
      end
      if (write_out) begin
        Result    <= fin_res;
        Result_hi <= fin_hi;
        CB_out    <= fin_cb;
        Zero      <= fin_zero;
        Neg       <= fin_res[N-1];
        Ovf       <= fin_ovf;
        DivZero   <= fin_dz;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_nb.sv
// Directed bench for alu_seq_nb (N=4): expected results are queued at Start and
// compared against the DUT whenever Done pulses.
module tb_alu_seq_nb;

  localparam int N = 4;
  localparam int W = 2*N + 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [N-1:0] A, B;
  logic         CB_in;
  logic [3:0]   Mode;
  logic [N-1:0] Result, Result_hi;
  logic         CB_out, Zero, Neg, Ovf, DivZero, Busy, Done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  alu_seq_nb #(.N(N)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .CB_in(CB_in), .Mode(Mode),
    .Result(Result), .Result_hi(Result_hi), .CB_out(CB_out), .Zero(Zero), .Neg(Neg),
    .Ovf(Ovf), .DivZero(DivZero), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  // Reference behaviour packed as {Result, Result_hi, CB_out, Zero, Neg, Ovf, DivZero}.
  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cb, input logic [3:0] mode);
    logic [N-1:0]   r, h;
    logic           c, z, o, dz;
    logic [2*N-1:0] p;
    int             s, sa, sb, lim_hi, lim_lo;
    r = '0; h = '0; c = 1'b0; o = 1'b0; dz = 1'b0; p = '1;
    sa = $signed(a);
    sb = $signed(b);
    lim_hi = (1 << (N-1)) - 1;
    lim_lo = -(1 << (N-1));
    case (mode)
      4'd0: begin
        s = int'(a) + int'(b) + int'(cb);
        r = s[N-1:0];
        c = s[N];
        o = ((sa + sb + int'(cb)) > lim_hi) || ((sa + sb + int'(cb)) < lim_lo);
      end
      4'd1: begin
        s = int'(a) - int'(b) - int'(cb);
        r = s[N-1:0];
        c = (s < 0);
        o = ((sa - sb - int'(cb)) > lim_hi) || ((sa - sb - int'(cb)) < lim_lo);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a + N'(1); c = (a == '1); end
      4'd7: begin r = a - N'(1); c = (a == '0); end
      4'd8: begin
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        r = p[N-1:0];
        h = p[2*N-1:N];
        o = (h != '0);
      end
      4'd9: begin
        if (b == '0) begin r = '1; h = a; dz = 1'b1; end
        else begin r = a / b; h = a % b; end
      end
      default: ;
    endcase
    z = (mode == 4'd8) ? (p == '0) : (r == '0);
    return {r, h, c, z, r[N-1], o, dz};
  endfunction

  function automatic logic [W-1:0] observed();
    return {Result, Result_hi, CB_out, Zero, Neg, Ovf, DivZero};
  endfunction

  // Scoreboard: every Done pops the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    string        t;
    if (!rst && Done) begin
      checks++;
      assert (exp_q.size() != 0)
        else begin errors++; $error("[TB] FAIL unexpected_done observed=Done=1 expected=no Done"); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (observed() === e)
          else begin errors++; $error("[TB] FAIL %s observed=%h expected=%h", t, observed(), e); end
        checks++;
        assert (Busy === 1'b0)
          else begin errors++; $error("[TB] FAIL %s_busy_at_done observed=%b expected=0", t, Busy); end
      end
    end
  end

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic cb,
                       input logic [3:0] mode, input string tag);
    A = a; B = b; CB_in = cb; Mode = mode; Start = 1'b1;
    exp_q.push_back(model(a, b, cb, mode));
    tag_q.push_back(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0)
      else begin errors++; $error("[TB] FAIL %s_timeout observed=%0d pending expected=0", tag, exp_q.size()); end
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
      else begin errors++; $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv); end
  endtask

  task automatic run_single(input logic [N-1:0] a, input logic [N-1:0] b, input logic cb,
                            input logic [3:0] mode, input string tag);
    drive(a, b, cb, mode, tag);
    @(negedge clk);
    Start = 1'b0;
    wait_idle(tag);
  endtask

  task automatic run_multi(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] mode,
                           input string tag, input bit inject);
    int busy = 0;
    drive(a, b, 1'b0, mode, tag);
    @(negedge clk);
    Start = 1'b0;
    while (Busy === 1'b1 && busy < 20) begin
      busy++;
      if (inject && busy == 2) begin
        A = '0; B = '0; CB_in = 1'b0; Mode = 4'd0; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
    Start = 1'b0;
    checks++;
    assert (busy == N)
      else begin errors++; $error("[TB] FAIL %s_busy_cycles observed=%0d expected=%0d", tag, busy, N); end
    wait_idle(tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst = 1'b0; Start = 1'b0; A = '0; B = '0; CB_in = 1'b0; Mode = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    assert ({observed(), Busy, Done} === '0)
      else begin errors++; $error("[TB] FAIL reset_state observed=%h expected=0", {observed(), Busy, Done}); end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] ADD / SUB / INC");
    run_single(4'd9, 4'd8, 1'b1, 4'd0, "add_9_8_1");
    check_bit("done_one_cycle", Done, 1'b0);
    run_single(4'd3, 4'd5, 1'b0, 4'd1, "sub_3_5");
    run_single(4'd15, 4'd0, 1'b0, 4'd6, "inc_15");
    run_single(4'd0, 4'd0, 1'b0, 4'd7, "dec_0");
    run_single(4'd12, 4'd10, 1'b0, 4'd4, "xor_12_10");

    $display("[TB] MUL with ignored mid-Busy Start");
    run_multi(4'd15, 4'd15, 4'd8, "mul_15_15", 1'b1);
    run_multi(4'd0, 4'd7, 4'd8, "mul_0_7", 1'b0);

    $display("[TB] DIV and divide by zero");
    run_multi(4'd13, 4'd4, 4'd9, "div_13_4", 1'b0);
    run_multi(4'd6, 4'd0, 4'd9, "div_6_0", 1'b0);
    run_single(4'd1, 4'd1, 1'b0, 4'd0, "add_clears_divzero");

    $display("[TB] reset during MUL");
    drive(4'd15, 4'd15, 1'b0, 4'd8, "mul_aborted");
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    assert ({observed(), Busy, Done} === '0)
      else begin errors++; $error("[TB] FAIL reset_mid_mul observed=%h expected=0", {observed(), Busy, Done}); end
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_bit("no_done_after_reset", Done, 1'b0);
    end
    run_single(4'd2, 4'd3, 1'b0, 4'd0, "add_2_3_after_reset");

    $display("[TB] back-to-back ADD and illegal mode");
    for (int i = 0; i < 6; i++) begin
      drive(N'(i), 4'd3, 1'b0, 4'd0, "add_stream");
      if (i >= 2) check_bit("done_every_cycle", Done, 1'b1);
      @(negedge clk);
    end
    Start = 1'b0;
    wait_idle("add_stream");
    run_single(4'd5, 4'd6, 1'b1, 4'hF, "illegal_mode");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
